// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receiver (and its TX sibling): FSM state
//   encoding, parity mode constants, default oversampling/baud settings and
//   the 3-sample majority helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE,
        ST_ERR
    } uart_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // 100 MHz / (9600 baud * 16)
    localparam int DEFAULT_TICK_DIV = 651;
    localparam int DEFAULT_OVS      = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Oversample tick generator: counts 0..TICK_DIV-1 and pulses tick for one
//   clk at the wrap. A synchronous clear restarts the count so the first tick
//   lands exactly TICK_DIV cycles after the clear.
// Ports
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   clr   in  synchronous counter clear (start-bit edge)
//   tick  out 1-cycle oversample strobe
// ---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs
//   Oversampling UART receiver. rx is synchronised, sampled OVS times per bit
//   and each bit is decided by a majority of the three samples around
//   mid-bit. Optional parity, 1 or 2 stop bits, parity/framing/break flags.
// Ports
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   rx         in  serial line, idle high, asynchronous to clk
//   data       out last good word (LSB first on the line)
//   data_valid out 1-cycle pulse, data updated
//   parity_err out 1-cycle pulse with data_valid on parity mismatch
//   frame_err  out 1-cycle pulse, a stop bit was sampled 0
//   break_det  out 1-cycle pulse with frame_err, whole frame was 0
//   busy       out high from start detect until return to IDLE
// ---------------------------------------------------------------------------
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVS        = DEFAULT_OVS,
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = PAR_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             break_det,
    output logic             busy
);

    localparam int            SW        = $clog2(OVS);
    localparam logic [SW-1:0] S_V0      = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OVS/2);
    localparam logic [SW-1:0] S_V2      = SW'(OVS/2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD == PAR_ODD);

    // ---------------- synchroniser and start-edge detect -------------------
    logic rx_meta, rx_s, rx_s_d;

    // Preset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    uart_state_t state, state_nxt;
    logic        start_det;
    logic        tick;

    assign start_det = (state == ST_IDLE) && rx_s_d && !rx_s;

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (start_det),
        .tick  (tick)
    );

    // ---------------- sample counter and majority vote ---------------------
    logic [SW-1:0] s_cnt;
    logic          v0, v1;
    logic          vote, vote_now;

    // The third sample is taken live, so the vote resolves on that tick.
    assign vote     = maj3(v0, v1, rx_s);
    assign vote_now = tick && (s_cnt == S_V2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_cnt <= '0;
            v0    <= 1'b1;
            v1    <= 1'b1;
        end else if (start_det) begin
            s_cnt <= '0;
        end else if (tick) begin
            s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);
            if (s_cnt == S_V0) v0 <= rx_s;
            if (s_cnt == S_V1) v1 <= rx_s;
        end
    end

    // ---------------- frame datapath ---------------------------------------
    logic [WIDTH-1:0] shreg;
    logic [3:0]       bit_cnt;
    logic             stop_cnt;
    logic             par_bit;
    logic             par_mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            par_mis  <= 1'b0;
        end else if (start_det) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            par_mis  <= 1'b0;
        end else if (vote_now) begin
            case (state)
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shreg   <= {vote, shreg[WIDTH-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                ST_PARITY: begin
                    par_bit <= vote;
                    par_mis <= vote != (^shreg ^ ODD);
                end
                ST_STOP: stop_cnt <= stop_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    logic go_done, go_err;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        go_done   = 1'b0;
        go_err    = 1'b0;
        case (state)
            ST_IDLE:   if (start_det) state_nxt = ST_START;
            ST_START:  if (vote_now) state_nxt = vote ? ST_IDLE : ST_DATA;
            ST_DATA:   if (vote_now && bit_cnt == LAST_BIT)
                           state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (vote_now) state_nxt = ST_STOP;
            ST_STOP: begin
                if (vote_now) begin
                    if (!vote) begin
                        state_nxt = ST_ERR;
                        go_err    = 1'b1;
                    end else if (stop_cnt == LAST_STOP) begin
                        state_nxt = ST_DONE;
                        go_done   = 1'b1;
                    end
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERR:    if (rx_s) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Flags are registered on entry to DONE/ERR so they line up with the
    // single cycle spent in DONE and pulse once even while ERR is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            data_valid <= go_done;
            parity_err <= go_done && par_mis;
            frame_err  <= go_err;
            break_det  <= go_err && (shreg == '0) && !par_bit;
            if (go_done) data <= shreg;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
